ln_param_loader: RTL and testbench
==================================

Name: ln_param_loader

Overview:
Sequenced, double-buffered loader for layernorm affine parameters (gamma, beta). It accepts fetch beats over a valid/ready stream and assembles them into a shadow bank. It then commits the shadow bank atomically to the active bank that feeds the layernorm execution unit. Segment counts are parametrised, replacing fixed low/high/beta write strobes, so wider gamma/beta element formats need no new ports.

Parameters:
DATA_W, 1408, width of one fetch beat (176 elements x 8 bit)
GAMMA_SEGS, 2, beats forming gamma; segment 0 occupies the LSBs
BETA_SEGS, 1, beats forming beta; segment 0 occupies the LSBs
CNT_W, $clog2(GAMMA_SEGS+BETA_SEGS+1), beat counter width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
load_start  in  1  begin (or restart) a parameter load
invalidate  in  1  clear params_valid
in_valid  in  1  fetch beat valid
in_ready  out  1  loader accepts beat
in_data  in  DATA_W  fetch beat payload
eu_busy  in  1  EU is consuming active params; blocks commit
gamma  out  GAMMA_SEGS*DATA_W  active gamma bank
beta  out  BETA_SEGS*DATA_W  active beta bank
params_valid  out  1  active bank holds a committed load
busy  out  1  state != IDLE
load_done  out  1  one-cycle pulse on commit
restart_err  out  1  one-cycle pulse when a load is aborted by load_start
beat_cnt  out  CNT_W  beats accepted in the current load

Behaviour:
- Reset (async assert, sync release): state IDLE; beat_cnt 0; shadow and active banks 0; params_valid 0; load_done 0; restart_err 0; in_ready 0; busy 0.
- States:
  - IDLE -> LOAD on load_start.
  - LOAD -> COMMIT when the beat with beat_cnt = GAMMA_SEGS+BETA_SEGS-1 is accepted.
  - COMMIT -> IDLE when eu_busy = 0.
- in_ready = (state == LOAD) && !load_start. A beat is accepted when in_valid && in_ready.
- Beat placement:
  - Accepted beat k < GAMMA_SEGS writes shadow gamma segment k, bits [k*DATA_W +: DATA_W].
  - Otherwise it writes shadow beta segment k-GAMMA_SEGS.
  - beat_cnt increments on each accepted beat.
- Commit: in COMMIT with eu_busy = 0:
  - active <= shadow on that edge;
  - params_valid <= 1;
  - load_done pulses for the cycle after the edge;
  - beat_cnt <= 0.
  - With eu_busy = 1, the loader holds in COMMIT indefinitely. in_ready stays 0 and active stays unchanged.
- Latency: last beat accepted in cycle t with eu_busy low -> new gamma/beta, params_valid = 1 and load_done = 1 all visible in cycle t+2.
- Active bank is stable at all times except the single commit edge. The EU never observes a partial load.
- load_start in LOAD: restart. beat_cnt <= 0, state stays LOAD, restart_err pulses next cycle. Shadow contents are don't-care and are overwritten. Any beat presented in that cycle is not accepted (in_ready = 0).
- load_start in COMMIT: ignored; no pulse.
- load_start in IDLE: params_valid is unchanged, so old params remain usable during the load.
- invalidate: params_valid <= 0 in any state. If it coincides with a commit edge, the commit wins (params_valid = 1).
- in_valid outside LOAD: ignored, no state change.
- Reset asserted mid-load or mid-commit: immediate return to reset values; partial load discarded.

Test Plan:
1. DATA_W=8, defaults. load_start, then beats 0x11, 0x22, 0x33 back-to-back, eu_busy=0 -> gamma=0x2211, beta=0x33, params_valid=1 and load_done=1 exactly 2 cycles after the 0x33 beat. beat_cnt sequence 0,1,2,3,0.
2. Same load with eu_busy=1 for 5 cycles after the last beat -> gamma/beta hold prior values (0) and in_ready=0 for those cycles. Commit lands on the edge after eu_busy falls; load_done is a single pulse.
3. Restart: load_start, beats 0xAA, 0xBB, then load_start again, then 0x01, 0x02, 0x03 -> restart_err pulses once; final gamma=0x0201, beta=0x03. 0xAA/0xBB never appear on outputs.
4. With params loaded, pulse invalidate in IDLE -> params_valid=0, gamma/beta unchanged. Invalidate coincident with the commit edge -> params_valid=1.
5. GAMMA_SEGS=3, BETA_SEGS=2, DATA_W=8, in_valid toggled randomly -> five accepted beats 1..5 give gamma=0x030201, beta=0x0504. Stalled cycles do not advance beat_cnt.
6. Assert rst after 1 of 3 beats -> all outputs return to 0 asynchronously. A fresh full load then completes normally.

Source files
------------

// File: rtl/ln_param_loader.sv
// Double-buffered gamma/beta loader: fetch beats fill a shadow bank, which is
// copied to the active bank in one edge once the execution unit is not busy.
module ln_param_loader #(
    parameter int DATA_W     = 1408,
    parameter int GAMMA_SEGS = 2,
    parameter int BETA_SEGS  = 1,
    localparam int CNT_W     = $clog2(GAMMA_SEGS + BETA_SEGS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic                         invalidate,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         eu_busy,
    output logic [GAMMA_SEGS*DATA_W-1:0] gamma,
    output logic [BETA_SEGS*DATA_W-1:0]  beta,
    output logic                         params_valid,
    output logic                         busy,
    output logic                         load_done,
    output logic                         restart_err,
    output logic [CNT_W-1:0]             beat_cnt,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(GAMMA_SEGS + BETA_SEGS - 1);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_data must be stable while in_valid is high, and in_ready never
    // depends on in_valid.

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [GAMMA_SEGS*DATA_W-1:0]   sh_gamma_q, sh_gamma_d;
    logic [BETA_SEGS*DATA_W-1:0]    sh_beta_q, sh_beta_d;
    logic [GAMMA_SEGS*DATA_W-1:0]   act_gamma_q, act_gamma_d;
    logic [BETA_SEGS*DATA_W-1:0]    act_beta_q, act_beta_d;
    logic                           pv_q, pv_d;
    logic                           done_q, done_d;
    logic                           rerr_q, rerr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_gamma_q  <= '0;
            sh_beta_q   <= '0;
            act_gamma_q <= '0;
            act_beta_q  <= '0;
            pv_q        <= 1'b0;
            done_q      <= 1'b0;
            rerr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_gamma_q  <= sh_gamma_d;
            sh_beta_q   <= sh_beta_d;
            act_gamma_q <= act_gamma_d;
            act_beta_q  <= act_beta_d;
            pv_q        <= pv_d;
            done_q      <= done_d;
            rerr_q      <= rerr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_gamma_d  = sh_gamma_q;
        sh_beta_d   = sh_beta_q;
        act_gamma_d = act_gamma_q;
        act_beta_d  = act_beta_q;
        pv_d        = pv_q;
        done_d      = 1'b0;
        rerr_d      = 1'b0;
        in_ready    = (state_q == LOAD) && !load_start;

        // A commit later in this block overrides the invalidate.
        if (invalidate) begin
            pv_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    cnt_d  = '0;
                    rerr_d = 1'b1;
                end else if (in_valid) begin
                    for (int i = 0; i < GAMMA_SEGS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            sh_gamma_d[i*DATA_W +: DATA_W] = in_data;
                        end
                    end
                    for (int i = 0; i < BETA_SEGS; i++) begin
                        if (cnt_q == CNT_W'(GAMMA_SEGS + i)) begin
                            sh_beta_d[i*DATA_W +: DATA_W] = in_data;
                        end
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                if (!eu_busy) begin
                    act_gamma_d = sh_gamma_q;
                    act_beta_d  = sh_beta_q;
                    pv_d        = 1'b1;
                    done_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gamma        = act_gamma_q;
    assign beta         = act_beta_q;
    assign params_valid = pv_q;
    assign busy         = (state_q != IDLE);
    assign load_done    = done_q;
    assign restart_err  = rerr_q;
    assign beat_cnt     = cnt_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_ln_param_loader.sv
// Bench for ln_param_loader: a 2+1 segment instance checked every cycle
// against a queue-based model, plus a 3+2 segment instance with random stalls.
module tb_ln_param_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Instance A: DATA_W=8, GAMMA_SEGS=2, BETA_SEGS=1
    logic        a_load_start = 0, a_invalidate = 0, a_in_valid = 0, a_eu_busy = 0;
    logic [7:0]  a_in_data = 0;
    logic        a_in_ready, a_pv, a_busy, a_done, a_rerr;
    logic [15:0] a_gamma;
    logic [7:0]  a_beta;
    logic [1:0]  a_cnt, a_state;

    // Instance B: DATA_W=8, GAMMA_SEGS=3, BETA_SEGS=2
    logic        b_load_start = 0, b_invalidate = 0, b_in_valid = 0, b_eu_busy = 0;
    logic [7:0]  b_in_data = 0;
    logic        b_in_ready, b_pv, b_busy, b_done, b_rerr;
    logic [23:0] b_gamma;
    logic [15:0] b_beta;
    logic [2:0]  b_cnt;
    logic [1:0]  b_state;

    ln_param_loader #(.DATA_W(8), .GAMMA_SEGS(2), .BETA_SEGS(1)) u_a (
        .clk(clk), .rst(rst), .load_start(a_load_start), .invalidate(a_invalidate),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .eu_busy(a_eu_busy), .gamma(a_gamma), .beta(a_beta), .params_valid(a_pv),
        .busy(a_busy), .load_done(a_done), .restart_err(a_rerr), .beat_cnt(a_cnt),
        .state_dbg(a_state)
    );

    ln_param_loader #(.DATA_W(8), .GAMMA_SEGS(3), .BETA_SEGS(2)) u_b (
        .clk(clk), .rst(rst), .load_start(b_load_start), .invalidate(b_invalidate),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .eu_busy(b_eu_busy), .gamma(b_gamma), .beta(b_beta), .params_valid(b_pv),
        .busy(b_busy), .load_done(b_done), .restart_err(b_rerr), .beat_cnt(b_cnt),
        .state_dbg(b_state)
    );

    function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Model of instance A: beats of the current load collect in a queue; the
    // active bank is a concatenation of the queue when it is committed.
    bit         m_loading, m_committing, m_pv, m_done, m_rerr;
    logic [7:0] m_beats[$];
    logic [15:0] m_gamma;
    logic [7:0]  m_beta;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_loading = 0; m_committing = 0; m_pv = 0; m_done = 0; m_rerr = 0;
            m_beats.delete();
            m_gamma = '0;
            m_beta  = '0;
        end else begin
            m_done = 0;
            m_rerr = 0;
            if (a_invalidate) m_pv = 0;
            if (m_committing) begin
                if (!a_eu_busy) begin
                    m_gamma = {m_beats[1], m_beats[0]};
                    m_beta  = m_beats[2];
                    m_pv = 1; m_done = 1; m_committing = 0;
                    m_beats.delete();
                end
            end else if (m_loading) begin
                if (a_load_start) begin
                    m_beats.delete();
                    m_rerr = 1;
                end else if (a_in_valid) begin
                    m_beats.push_back(a_in_data);
                    if (m_beats.size() == 3) begin
                        m_loading = 0;
                        m_committing = 1;
                    end
                end
            end else if (a_load_start) begin
                m_loading = 1;
                m_beats.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_gamma", 64'(a_gamma), 64'(m_gamma));
            check("a_beta", 64'(a_beta), 64'(m_beta));
            check("a_params_valid", 64'(a_pv), 64'(m_pv));
            check("a_load_done", 64'(a_done), 64'(m_done));
            check("a_restart_err", 64'(a_rerr), 64'(m_rerr));
            check("a_busy", 64'(a_busy), 64'(m_loading || m_committing));
            check("a_state_nonidle", 64'(a_state != 2'd0), 64'(m_loading || m_committing));
            check("a_beat_cnt", 64'(a_cnt), 64'(m_beats.size()));
            check("a_in_ready", 64'(a_in_ready), 64'(m_loading && !a_load_start));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [7:0] d);
        a_in_valid = 1'b1;
        a_in_data  = d;
        tick();
    endtask

    initial begin
        int acc;
        int cycles;
        bit took;

        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("rst_gamma", 64'(a_gamma), 64'h0);
        check("rst_beta", 64'(a_beta), 64'h0);
        check("rst_pv", 64'(a_pv), 64'h0);
        check("rst_busy", 64'(a_busy), 64'h0);
        check("rst_in_ready", 64'(a_in_ready), 64'h0);

        // Basic load, no stalls
        a_load_start = 1; tick(); a_load_start = 0;
        check("t1_cnt0", 64'(a_cnt), 64'd0);
        a_send(8'h11); check("t1_cnt1", 64'(a_cnt), 64'd1);
        a_send(8'h22); check("t1_cnt2", 64'(a_cnt), 64'd2);
        a_send(8'h33); a_in_valid = 0;
        check("t1_cnt3", 64'(a_cnt), 64'd3);
        check("t1_done_early", 64'(a_done), 64'd0);
        check("t1_gamma_early", 64'(a_gamma), 64'h0);
        tick();
        check("t1_gamma", 64'(a_gamma), 64'h2211);
        check("t1_beta", 64'(a_beta), 64'h33);
        check("t1_pv", 64'(a_pv), 64'd1);
        check("t1_done", 64'(a_done), 64'd1);
        check("t1_cnt_end", 64'(a_cnt), 64'd0);
        tick();
        check("t1_done_pulse", 64'(a_done), 64'd0);

        // Beats offered while idle are ignored
        a_send(8'hEE); a_send(8'hEF); a_in_valid = 0;
        check("idle_cnt", 64'(a_cnt), 64'd0);
        check("idle_busy", 64'(a_busy), 64'd0);

        // Commit held off by eu_busy; load_start in COMMIT is ignored
        a_load_start = 1; tick(); a_load_start = 0;
        a_send(8'h44); a_send(8'h55);
        a_eu_busy = 1;
        a_send(8'h66); a_in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            a_load_start = (i == 2);
            tick();
            check("t2_in_ready", 64'(a_in_ready), 64'd0);
            check("t2_gamma_hold", 64'(a_gamma), 64'h2211);
            check("t2_rerr", 64'(a_rerr), 64'd0);
        end
        a_load_start = 0;
        a_eu_busy = 0;
        tick();
        check("t2_gamma", 64'(a_gamma), 64'h5544);
        check("t2_beta", 64'(a_beta), 64'h66);
        check("t2_done", 64'(a_done), 64'd1);
        tick();
        check("t2_done_pulse", 64'(a_done), 64'd0);

        // Restart mid-load; the beat offered with load_start is refused
        a_load_start = 1; tick(); a_load_start = 0;
        a_send(8'hAA); a_send(8'hBB);
        a_load_start = 1; a_in_valid = 1; a_in_data = 8'hCC;
        tick();
        a_load_start = 0;
        check("t3_rerr", 64'(a_rerr), 64'd1);
        check("t3_cnt", 64'(a_cnt), 64'd0);
        a_send(8'h01);
        check("t3_rerr_pulse", 64'(a_rerr), 64'd0);
        a_send(8'h02); a_send(8'h03); a_in_valid = 0;
        tick();
        check("t3_gamma", 64'(a_gamma), 64'h0201);
        check("t3_beta", 64'(a_beta), 64'h03);

        // Invalidate while idle, then coincident with a commit edge
        tick();
        a_invalidate = 1; tick(); a_invalidate = 0;
        check("t4_pv_clr", 64'(a_pv), 64'd0);
        check("t4_gamma_keep", 64'(a_gamma), 64'h0201);
        a_load_start = 1; tick(); a_load_start = 0;
        a_send(8'h07); a_send(8'h08); a_send(8'h09); a_in_valid = 0;
        a_invalidate = 1; tick(); a_invalidate = 0;
        check("t4_commit_wins", 64'(a_pv), 64'd1);
        check("t4_gamma", 64'(a_gamma), 64'h0807);

        // Asynchronous reset after one beat, then a clean load
        a_load_start = 1; tick(); a_load_start = 0;
        a_send(8'h5A); a_in_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("t6_gamma", 64'(a_gamma), 64'h0);
        check("t6_beta", 64'(a_beta), 64'h0);
        check("t6_pv", 64'(a_pv), 64'd0);
        check("t6_busy", 64'(a_busy), 64'd0);
        check("t6_cnt", 64'(a_cnt), 64'd0);
        tick(); tick();
        rst = 1'b0;
        a_load_start = 1; tick(); a_load_start = 0;
        a_send(8'h0D); a_send(8'h0E); a_send(8'h0F); a_in_valid = 0;
        tick();
        check("t6_gamma_new", 64'(a_gamma), 64'h0E0D);
        check("t6_beta_new", 64'(a_beta), 64'h0F);
        check("t6_pv_new", 64'(a_pv), 64'd1);

        // Wider instance with random in_valid stalls
        b_load_start = 1; tick(); b_load_start = 0;
        acc = 0;
        cycles = 0;
        while (acc < 5 && cycles < 100) begin
            b_in_valid = 1'($urandom_range(0, 1));
            b_in_data  = 8'(acc + 1);
            took = b_in_valid;
            tick();
            if (took) acc++;
            check("t5_beat_cnt", 64'(b_cnt), 64'(acc));
            cycles++;
        end
        b_in_valid = 0;
        check("t5_accepted", 64'(acc), 64'd5);
        tick();
        check("t5_gamma", 64'(b_gamma), 64'h030201);
        check("t5_beta", 64'(b_beta), 64'h0504);
        check("t5_pv", 64'(b_pv), 64'd1);
        check("t5_done", 64'(b_done), 64'd1);
        tick();
        check("t5_busy", 64'(b_busy), 64'd0);
        check("t5_rerr", 64'(b_rerr), 64'd0);
        check("t5_in_ready", 64'(b_in_ready), 64'd0);
        check("t5_state_idle", 64'(b_state), 64'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
